// File: rtl/mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and main-memory line-port signals around mem_arbiter.
// The slave modport is the arbiter's view; master is the caches/memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int LINE_W = 128
) ();

    logic              ic_req_i;
    logic [ADDR_W-1:0] ic_addr_i;
    logic              ic_ready_o;
    logic              ic_err_o;
    logic [LINE_W-1:0] ic_rdata_o;

    logic              dc_req_i;
    logic              dc_we_i;
    logic [ADDR_W-1:0] dc_addr_i;
    logic [LINE_W-1:0] dc_wdata_i;
    logic              dc_ready_o;
    logic              dc_err_o;
    logic [LINE_W-1:0] dc_rdata_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_wdata_o;
    logic [LINE_W-1:0] mem_rdata_i;
    logic              mem_ready_i;

    logic [1:0]        grant_o;

    modport slave (
        input  ic_req_i, ic_addr_i,
        output ic_ready_o, ic_err_o, ic_rdata_o,
        input  dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i,
        output dc_ready_o, dc_err_o, dc_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i, mem_ready_i,
        output grant_o
    );

    modport master (
        output ic_req_i, ic_addr_i,
        input  ic_ready_o, ic_err_o, ic_rdata_o,
        output dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i,
        input  dc_ready_o, dc_err_o, dc_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i, mem_ready_i,
        input  grant_o
    );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory line port between I-cache refills
// and D-cache refills/writebacks, one transaction at a time, with a timeout watchdog.
module mem_arbiter #(
    parameter int ADDR_W  = 20,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);

    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'((1 << OFF_W) - 1);
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'b00,
        GRANT_I    = 2'b01,
        GRANT_D    = 2'b10
    } grant_t;

    state_t            state;
    grant_t            grant_q;
    grant_t            last_owner;
    logic [CNT_W-1:0]  cnt;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [LINE_W-1:0] mem_wdata_q;
    logic [LINE_W-1:0] rdata_q;
    logic              ic_ready_q;
    logic              ic_err_q;
    logic              dc_ready_q;
    logic              dc_err_q;

    logic              pick_i;
    logic              timed_out;

    // On a tie the cache that did not go last wins; last_owner resets to D so boot fetch goes first.
    assign pick_i    = bus.ic_req_i && (!bus.dc_req_i || (last_owner == GRANT_D));
    assign timed_out = (TIMEOUT != 0) && (cnt == CNT_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant_q     <= GRANT_NONE;
            last_owner  <= GRANT_D;
            cnt         <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            ic_ready_q  <= 1'b0;
            ic_err_q    <= 1'b0;
            dc_ready_q  <= 1'b0;
            dc_err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ic_ready_q <= 1'b0;
                    ic_err_q   <= 1'b0;
                    dc_ready_q <= 1'b0;
                    dc_err_q   <= 1'b0;
                    cnt        <= '0;
                    if (bus.ic_req_i || bus.dc_req_i) begin
                        mem_req_q <= 1'b1;
                        state     <= MEM;
                        if (pick_i) begin
                            grant_q     <= GRANT_I;
                            last_owner  <= GRANT_I;
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= bus.ic_addr_i & ADDR_MASK;
                            mem_wdata_q <= '0;
                        end else begin
                            grant_q     <= GRANT_D;
                            last_owner  <= GRANT_D;
                            mem_we_q    <= bus.dc_we_i;
                            mem_addr_q  <= bus.dc_addr_i & ADDR_MASK;
                            mem_wdata_q <= bus.dc_we_i ? bus.dc_wdata_i : '0;
                        end
                    end else begin
                        grant_q <= GRANT_NONE;
                    end
                end

                // A ready arriving in the limit cycle beats the watchdog.
                MEM: begin
                    if (bus.mem_ready_i || timed_out) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state     <= RESP;
                        if (bus.mem_ready_i && !mem_we_q) begin
                            rdata_q <= bus.mem_rdata_i;
                        end else begin
                            rdata_q <= '0;
                        end
                        if (grant_q == GRANT_I) begin
                            ic_ready_q <= 1'b1;
                            ic_err_q   <= !bus.mem_ready_i;
                        end else begin
                            dc_ready_q <= 1'b1;
                            dc_err_q   <= !bus.mem_ready_i;
                        end
                    end else if (TIMEOUT != 0) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                RESP: begin
                    ic_ready_q <= 1'b0;
                    ic_err_q   <= 1'b0;
                    dc_ready_q <= 1'b0;
                    dc_err_q   <= 1'b0;
                    grant_q    <= GRANT_NONE;
                    state      <= IDLE;
                end

                default: begin
                    state     <= IDLE;
                    grant_q   <= GRANT_NONE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant_o     = grant_q;
    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.ic_ready_o  = ic_ready_q;
    assign bus.ic_err_o    = ic_err_q;
    assign bus.ic_rdata_o  = rdata_q;
    assign bus.dc_ready_o  = dc_ready_q;
    assign bus.dc_err_o    = dc_err_q;
    assign bus.dc_rdata_o  = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single requesters, contention, watchdog, async reset
// and stray memory ready pulses, run with an 8-cycle watchdog.
module tb_mem_arbiter;

    localparam int ADDR_W  = 20;
    localparam int LINE_W  = 128;
    localparam int TIMEOUT = 8;

    localparam logic [LINE_W-1:0] RD_LINE = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [LINE_W-1:0] WR_LINE = {16{8'hA5}};
    localparam logic [LINE_W-1:0] D_LINE  = 128'hDEADBEEF_CAFEF00D_13579BDF_2468ACE0;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    mem_arbiter #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic ic_req, input logic dc_req, input logic dc_we,
                                  input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wdata);
        bus.ic_req_i   = ic_req;
        bus.ic_addr_i  = addr;
        bus.dc_req_i   = dc_req;
        bus.dc_we_i    = dc_we;
        bus.dc_addr_i  = addr;
        bus.dc_wdata_i = wdata;
    endtask

    task automatic check_output(input string tag, input logic [LINE_W-1:0] observed,
                                input logic [LINE_W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0);
        bus.mem_ready_i = 1'b0;
        bus.mem_rdata_i = '0;
        repeat (2) tick();

        check_output("reset_mem_req", bus.mem_req_o, 0);
        check_output("reset_grant", bus.grant_o, 0);
        check_output("reset_ic_ready", bus.ic_ready_o, 0);
        check_output("reset_dc_ready", bus.dc_ready_o, 0);
        check_output("reset_mem_addr", bus.mem_addr_o, 0);
        rst = 1'b0;

        // I-cache read alone, memory answers in the 3rd MEM cycle
        apply_stimulus(1'b1, 1'b0, 1'b0, 20'h01004, '0);
        tick();
        check_output("ird_mem_req", bus.mem_req_o, 1);
        check_output("ird_mem_addr", bus.mem_addr_o, 20'h01000);
        check_output("ird_mem_we", bus.mem_we_o, 0);
        check_output("ird_grant", bus.grant_o, 2'b01);
        tick();
        check_output("ird_mem_req_c2", bus.mem_req_o, 1);
        tick();
        check_output("ird_mem_req_c3", bus.mem_req_o, 1);
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = RD_LINE;
        tick();
        check_output("ird_ic_ready", bus.ic_ready_o, 1);
        check_output("ird_ic_rdata", bus.ic_rdata_o, RD_LINE);
        check_output("ird_ic_err", bus.ic_err_o, 0);
        check_output("ird_dc_ready", bus.dc_ready_o, 0);
        check_output("ird_resp_mem_req", bus.mem_req_o, 0);
        bus.mem_ready_i = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        check_output("ird_idle_ready", bus.ic_ready_o, 0);
        check_output("ird_idle_grant", bus.grant_o, 0);

        // D-cache line write; read data from memory must not reach rdata
        apply_stimulus(1'b0, 1'b1, 1'b1, 20'h0ABCF, WR_LINE);
        tick();
        check_output("dwr_mem_we", bus.mem_we_o, 1);
        check_output("dwr_mem_addr", bus.mem_addr_o, 20'h0ABC0);
        check_output("dwr_mem_wdata", bus.mem_wdata_o, WR_LINE);
        check_output("dwr_grant", bus.grant_o, 2'b10);
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = '1;
        tick();
        check_output("dwr_dc_ready", bus.dc_ready_o, 1);
        check_output("dwr_dc_rdata", bus.dc_rdata_o, 0);
        check_output("dwr_dc_err", bus.dc_err_o, 0);
        check_output("dwr_ic_ready", bus.ic_ready_o, 0);
        check_output("dwr_resp_mem_we", bus.mem_we_o, 0);
        bus.mem_ready_i = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        check_output("dwr_idle_ready", bus.dc_ready_o, 0);

        // D read that fills rdata, so the later timeout's zero data is observable
        apply_stimulus(1'b0, 1'b1, 1'b0, 20'h00230, '0);
        tick();
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = D_LINE;
        tick();
        check_output("drd_dc_rdata", bus.dc_rdata_o, D_LINE);
        bus.mem_ready_i = 1'b0;
        tick();

        // Timeout: memory silent, mem_req_o must stay high exactly 8 cycles
        for (int i = 0; i < TIMEOUT; i++) begin
            tick();
            check_output($sformatf("tmo_mem_req_c%0d", i + 1), bus.mem_req_o, 1);
            check_output($sformatf("tmo_no_ready_c%0d", i + 1), bus.dc_ready_o, 0);
        end
        tick();
        check_output("tmo_mem_req_drop", bus.mem_req_o, 0);
        check_output("tmo_dc_ready", bus.dc_ready_o, 1);
        check_output("tmo_dc_err", bus.dc_err_o, 1);
        check_output("tmo_dc_rdata", bus.dc_rdata_o, 0);
        check_output("tmo_ic_ready", bus.ic_ready_o, 0);
        apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        check_output("tmo_idle_err", bus.dc_err_o, 0);

        // Timeout variant: ready in the 8th MEM cycle wins over the watchdog
        apply_stimulus(1'b0, 1'b1, 1'b0, 20'h00450, '0);
        for (int i = 0; i < TIMEOUT; i++) begin
            tick();
            check_output($sformatf("tmv_mem_req_c%0d", i + 1), bus.mem_req_o, 1);
        end
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = RD_LINE;
        tick();
        check_output("tmv_dc_ready", bus.dc_ready_o, 1);
        check_output("tmv_dc_err", bus.dc_err_o, 0);
        check_output("tmv_dc_rdata", bus.dc_rdata_o, RD_LINE);
        bus.mem_ready_i = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0);
        tick();

        // Contention from reset: grants alternate I, D, I, D with one ready each
        rst = 1'b1;
        apply_stimulus(1'b1, 1'b1, 1'b0, 20'h00800, '0);
        tick();
        rst = 1'b0;
        for (int g = 0; g < 4; g++) begin
            tick();
            check_output($sformatf("cnt_grant_%0d", g), bus.grant_o, (g % 2 == 0) ? 2'b01 : 2'b10);
            check_output($sformatf("cnt_mem_ready_quiet_%0d", g), bus.ic_ready_o | bus.dc_ready_o, 0);
            bus.mem_ready_i = 1'b1;
            bus.mem_rdata_i = D_LINE;
            tick();
            bus.mem_ready_i = 1'b0;
            check_output($sformatf("cnt_ic_ready_%0d", g), bus.ic_ready_o, (g % 2 == 0) ? 1 : 0);
            check_output($sformatf("cnt_dc_ready_%0d", g), bus.dc_ready_o, (g % 2 == 0) ? 0 : 1);
            tick();
            check_output($sformatf("cnt_idle_grant_%0d", g), bus.grant_o, 0);
            check_output($sformatf("cnt_idle_ready_%0d", g), bus.ic_ready_o | bus.dc_ready_o, 0);
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0);
        tick();

        // Reset mid-MEM: outputs drop asynchronously, then a tie goes to I
        apply_stimulus(1'b0, 1'b1, 1'b0, 20'h00C00, '0);
        tick();
        check_output("rmm_mem_req_before", bus.mem_req_o, 1);
        check_output("rmm_grant_before", bus.grant_o, 2'b10);
        #2;
        rst = 1'b1;
        #1;
        check_output("rmm_mem_req_async", bus.mem_req_o, 0);
        check_output("rmm_grant_async", bus.grant_o, 0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 20'h00C00, '0);
        tick();
        check_output("rmm_no_dc_ready", bus.dc_ready_o, 0);
        rst = 1'b0;
        tick();
        check_output("rmm_tie_grant", bus.grant_o, 2'b01);
        check_output("rmm_no_ready_mem", bus.ic_ready_o | bus.dc_ready_o, 0);
        apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0);
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = RD_LINE;
        tick();
        bus.mem_ready_i = 1'b0;
        check_output("rmm_ic_ready", bus.ic_ready_o, 1);
        check_output("rmm_dc_ready", bus.dc_ready_o, 0);
        tick();

        // Spurious mem_ready_i in IDLE
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = WR_LINE;
        tick();
        check_output("spi_mem_req", bus.mem_req_o, 0);
        check_output("spi_grant", bus.grant_o, 0);
        check_output("spi_ready", bus.ic_ready_o | bus.dc_ready_o, 0);
        check_output("spi_rdata_kept", bus.ic_rdata_o, RD_LINE);
        bus.mem_ready_i = 1'b0;

        // Spurious mem_ready_i held through RESP
        apply_stimulus(1'b0, 1'b1, 1'b0, 20'h00E00, '0);
        tick();
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = D_LINE;
        tick();
        check_output("spr_dc_ready", bus.dc_ready_o, 1);
        apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        check_output("spr_idle_ready", bus.ic_ready_o | bus.dc_ready_o, 0);
        check_output("spr_idle_mem_req", bus.mem_req_o, 0);
        check_output("spr_idle_grant", bus.grant_o, 0);
        bus.mem_ready_i = 1'b0;
        tick();
        check_output("spr_still_idle", bus.mem_req_o, 0);

        $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory line port between the instruction-cache refill path (read only) and the data-cache refill/writeback path (read or write).
- Sits between both cache controllers and the memory interface.
- Transfers whole cache lines, one outstanding transaction at a time.
- Round-robin arbitration, registered outputs, and a timeout watchdog that returns an error response if memory never answers.

Parameters:
- ADDR_W, 20, physical address width (matches PHY_LEN).
- LINE_W, 128, cache line width in bits. ICLLEN and DCLLEN are both 128, so one width serves both caches.
- TIMEOUT, 255, maximum number of MEM-state cycles before error. 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ic_req_i  in  1  I-cache line read request, level.
- ic_addr_i  in  ADDR_W  I-cache line address.
- ic_ready_o  out  1  I-cache completion pulse.
- ic_err_o  out  1  I-cache timeout error, valid with ic_ready_o.
- ic_rdata_o  out  LINE_W  read line, valid with ic_ready_o.
- dc_req_i  in  1  D-cache request, level.
- dc_we_i  in  1  1 = line write, 0 = line read.
- dc_addr_i  in  ADDR_W  D-cache line address.
- dc_wdata_i  in  LINE_W  D-cache write line.
- dc_ready_o  out  1  D-cache completion pulse.
- dc_err_o  out  1  D-cache timeout error, valid with dc_ready_o.
- dc_rdata_o  out  LINE_W  read line, valid with dc_ready_o.
- mem_req_o  out  1  memory request, level.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  line-aligned memory address.
- mem_wdata_o  out  LINE_W  memory write data.
- mem_rdata_i  in  LINE_W  memory read data, valid with mem_ready_i.
- mem_ready_i  in  1  memory completion, one-cycle pulse.
- grant_o  out  2  current owner: 01 = I, 10 = D, 00 = none.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - rst is asynchronous and active-high; it immediately forces state IDLE, all outputs 0, timeout counter 0, last_owner = D.
- FSM states: IDLE, MEM, RESP.
- IDLE:
  - Requests are sampled only in IDLE.
  - Single requester: grant it.
  - Both requesting: grant the one that is not last_owner. After reset the I-cache wins the first tie, so boot fetch goes first.
  - On grant, register:
    - owner into grant_o and last_owner;
    - mem_we_o = dc_we_i for D, 0 for I;
    - mem_addr_o = address with its low log2(LINE_W/8) bits forced to 0 (4 bits at default);
    - mem_wdata_o = dc_wdata_i for a D write, else 0.
  - Assert mem_req_o, clear the counter, go to MEM.
  - No request: remain in IDLE, grant_o = 00.
- MEM:
  - mem_req_o and all mem_* outputs are held stable.
  - mem_ready_i high: capture mem_rdata_i into the shared rdata register (0 for writes), err = 0, go to RESP.
  - Otherwise the counter increments. When the counter equals TIMEOUT-1 without ready (TIMEOUT != 0): rdata = 0, err = 1, go to RESP.
  - mem_req_o is therefore high for at most TIMEOUT cycles.
  - mem_ready_i in the limit cycle wins: no error.
- RESP:
  - mem_req_o = 0, mem_we_o = 0.
  - The owner's ready_o = 1 for exactly this cycle. Its err_o is set on timeout.
  - The non-owner's ready_o/err_o stay 0.
  - ic_rdata_o and dc_rdata_o both reflect the shared rdata register; the value is meaningful only with the owner's ready.
  - Next state IDLE; grant_o returns to 00 in IDLE.
- Requester handshake:
  - Hold req, address, we and wdata stable from assertion until ready is seen.
  - Deassert req on the edge after ready. A req still high in IDLE is a new request.
- Latency: request in IDLE at cycle 0 → mem_req_o high in cycle 1; mem_ready_i in cycle k → ready_o in cycle k+1. The minimum is 2 cycles (k = 1).
- Ignored inputs: mem_ready_i outside MEM, and requests during MEM/RESP (held requesters stay pending).
- Reset mid-transaction: the transaction is abandoned, no ready is issued, and mem_req_o drops asynchronously. The requester reissues after reset.
- No starvation: with both requesters continuously active, grants strictly alternate.

Test Plan:
- I-cache read alone:
  - Stimulus: ic_addr_i = 0x01004; mem_ready_i in the 3rd MEM cycle with rdata 0x0123…CDEF.
  - Required: mem_addr_o = 0x01000, mem_we_o = 0, grant_o = 01. ic_ready_o one cycle later with that data, ic_err_o = 0, dc_ready_o = 0.
- D-cache write:
  - Stimulus: dc_we_i = 1, addr 0x0ABCF, wdata 0xA5…A5.
  - Required: mem_we_o = 1, mem_addr_o = 0x0ABC0, mem_wdata_o = 0xA5…A5. dc_ready_o pulse, dc_rdata_o = 0.
- Contention:
  - Stimulus: both req held high from reset.
  - Required: grants in order I, D, I, D, with exactly one ready pulse per grant and no overlapping ready pulses.
- Timeout:
  - Stimulus: TIMEOUT = 8, D read, memory silent.
  - Required: mem_req_o high exactly 8 cycles, then dc_ready_o = dc_err_o = 1 for one cycle with rdata 0.
  - Variant: mem_ready_i in the 8th MEM cycle → err 0, data returned.
- Reset mid-MEM:
  - Stimulus: assert rst asynchronously during MEM.
  - Required: mem_req_o and grant_o drop to 0 before the next edge and no ready pulse occurs. After release, a tie grants I.
- Spurious ready:
  - Stimulus: mem_ready_i pulses while in IDLE and while in RESP.
  - Required: no state change and no ready_o.
